// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared encodings for the multicycle ARM control unit:
//                FSM state codes, ALU operation codes, data-processing cmd
//                field values, condition-code values and a cmd decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

    // ------------------------------------------------------------------
    // FSM state encoding
    // ------------------------------------------------------------------
    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;

    // ------------------------------------------------------------------
    // ALU operation codes (low three bits of ALUControl)
    // ------------------------------------------------------------------
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    // ------------------------------------------------------------------
    // Data-processing cmd field values (instr[24:21])
    // ------------------------------------------------------------------
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // ------------------------------------------------------------------
    // Instruction class (Op field)
    // ------------------------------------------------------------------
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ------------------------------------------------------------------
    // Condition codes (instr[31:28]); 4'b1111 is "never"
    // ------------------------------------------------------------------
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Decoded view of a data-processing cmd
    typedef struct packed {
        logic [2:0] alu;    // ALU operation to perform
        logic       known;  // cmd is implemented; gates the register write
        logic       cmp;    // compare only, no write-back state
        logic       arith;  // arithmetic op, so C and V are meaningful
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        d.alu   = ALU_ADD;
        d.known = 1'b1;
        d.cmp   = 1'b0;
        d.arith = 1'b0;
        case (cmd)
            CMD_ADD: begin d.alu = ALU_ADD; d.arith = 1'b1; end
            CMD_SUB: begin d.alu = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: d.alu = ALU_AND;
            CMD_ORR: d.alu = ALU_ORR;
            CMD_EOR: d.alu = ALU_EOR;
            CMD_MOV: d.alu = ALU_MOV;
            CMD_CMP: begin d.alu = ALU_SUB; d.arith = 1'b1; d.cmp = 1'b1; end
            // Unimplemented cmds behave as an ADD whose result is discarded
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
//  Module      : cond_logic
//  Description : NZCV flag register with split NZ / CV write enables and
//                condition-code evaluation against the stored flags.
//                o_cond_ex is the live evaluation; o_cond_ex_q is the value
//                captured while the instruction is being decoded.
//  Ports       : clk, rst (async, active-low)
//                i_nz_we / i_cv_we  : update N,Z / C,V from i_alu_flags
//                i_alu_flags        : {N,Z,C,V} from the ALU this cycle
//                i_cond             : instruction condition field
//                i_cond_latch       : capture o_cond_ex into o_cond_ex_q
//                o_cond_ex          : condition passes with stored flags
//                o_cond_ex_q        : captured condition result
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_logic
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_nz_we,
    input  logic       i_cv_we,
    input  logic [3:0] i_alu_flags,
    input  logic [3:0] i_cond,
    input  logic       i_cond_latch,
    output logic       o_cond_ex,
    output logic       o_cond_ex_q
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex_q;
    logic       cond_ex_d;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign {w_n, w_z, w_c, w_v} = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (i_nz_we) begin
            flags_d[3:2] = i_alu_flags[3:2];
        end
        if (i_cv_we) begin
            flags_d[1:0] = i_alu_flags[1:0];
        end
    end

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = ~(w_n ^ w_v);
            COND_LT: o_cond_ex = w_n ^ w_v;
            COND_GT: o_cond_ex = ~w_z & ~(w_n ^ w_v);
            COND_LE: o_cond_ex = w_z | (w_n ^ w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        cond_ex_d = cond_ex_q;
        if (i_cond_latch) begin
            cond_ex_d = o_cond_ex;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    assign o_cond_ex_q = cond_ex_q;

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Moore FSM sequencing ARM instructions through the shared-
//                memory multicycle datapath, with datapath control decode,
//                NZCV flags / condition evaluation and an optional memory
//                ready handshake on the fetch, load and store states.
//  Ports       : clk, rst (async, active-low)
//                Cond, Op, Funct, Rd  : instruction fields from the IR
//                ALUFlags             : {N,Z,C,V} from the ALU
//                mem_ready            : memory access completes this cycle
//                PCWrite, IRWrite, MemWrite, RegWrite : write strobes
//                AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
//                ALUControl           : datapath steering
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int MEM_WAIT  = 0,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl
);

    state_t   state_q;
    state_t   state_d;

    cmd_dec_t w_cmd_dec;
    logic     w_imm;
    logic     w_set_flags;
    logic     w_load;
    logic     w_pc_dest;
    logic     w_mem_go;
    logic     w_exec;
    logic     w_cond_ex;
    logic     w_cond_ex_q;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [2:0] w_alu_ctrl;

    assign w_cmd_dec   = decode_cmd(Funct[4:1]);
    assign w_imm       = Funct[5];
    assign w_set_flags = Funct[0];
    assign w_load      = Funct[0];
    assign w_pc_dest   = (Rd == 4'd15);
    // Without the handshake every memory access is single-cycle
    assign w_mem_go    = (MEM_WAIT == 0) || mem_ready;
    assign w_exec      = (state_q == S_EXECR) || (state_q == S_EXECI);

    cond_logic u_cond_logic (
        .clk          (clk),
        .rst          (rst),
        .i_nz_we      (w_exec & w_set_flags),
        .i_cv_we      (w_exec & w_set_flags & w_cmd_dec.arith),
        .i_alu_flags  (ALUFlags),
        .i_cond       (Cond),
        .i_cond_latch (state_q == S_DECODE),
        .o_cond_ex    (w_cond_ex),
        .o_cond_ex_q  (w_cond_ex_q)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (w_mem_go) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Uses the live evaluation: the captured copy only becomes
                // valid on the edge leaving this state.
                if (!w_cond_ex) begin
                    state_d = S_FETCH;
                end else begin
                    case (Op)
                        OP_MEM:  state_d = S_MEMADR;
                        OP_DP:   state_d = w_imm ? S_EXECI : S_EXECR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = w_load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (w_mem_go) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (w_mem_go) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR,
            S_EXECI:    state_d = w_cmd_dec.cmp ? S_FETCH : S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Post-decode write strobes are additionally qualified
    // by the captured condition so a corrupted state can never commit a
    // write for an instruction whose condition failed.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        w_alu_ctrl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                // Only Mealy term: a stalled fetch must not advance PC/IR
                w_ir_write = w_mem_go;
                w_pc_write = w_mem_go;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = w_cond_ex_q;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = w_cond_ex_q;
                w_pc_write  = w_cond_ex_q & w_pc_dest;
            end
            S_EXECR: begin
                w_alu_ctrl = w_cmd_dec.alu;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                w_alu_ctrl = w_cmd_dec.alu;
            end
            S_ALUWB: begin
                w_reg_write = w_cond_ex_q & w_cmd_dec.known;
                w_pc_write  = w_cond_ex_q & w_pc_dest;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                w_pc_write = w_cond_ex_q;
            end
            default: ;
        endcase
    end

    // Strobes are killed combinationally so nothing fires in a reset cycle
    assign PCWrite  = rst & w_pc_write;
    assign IRWrite  = rst & w_ir_write;
    assign MemWrite = rst & w_mem_write;
    assign RegWrite = rst & w_reg_write;

    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};
    assign ALUControl = ALUCTRL_W'(w_alu_ctrl);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Scoreboard bench. The driver walks each instruction through
//                its architectural phases, pushing the expected control word
//                of every cycle into a queue; a monitor pops and compares on
//                the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int ALUW = 4;

    logic            clk;
    logic            rst;
    logic [3:0]      Cond;
    logic [1:0]      Op;
    logic [5:0]      Funct;
    logic [3:0]      Rd;
    logic [3:0]      ALUFlags;
    logic            mem_ready;
    logic            PCWrite;
    logic            IRWrite;
    logic            MemWrite;
    logic            RegWrite;
    logic            AdrSrc;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ResultSrc;
    logic [1:0]      ImmSrc;
    logic [1:0]      RegSrc;
    logic [ALUW-1:0] ALUControl;

    multicycle_control_unit #(
        .MEM_WAIT  (1),
        .ALUCTRL_W (ALUW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [3:0] alu;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] m_flags  = 4'b0000;   // architectural NZCV of the model

    logic [3:0] known_cmds [7] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100,
                                   4'b0001, 4'b1101, 4'b1010};

    // ---------------- reference model helpers ----------------
    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU code and whether the result is written back, from the cmd table
    function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            4'b0001: return 3'd4;
            4'b1101: return 3'd5;
            4'b1010: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bit cmd_known(input logic [3:0] cmd);
        foreach (known_cmds[i]) if (known_cmds[i] == cmd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input string tag, input bit pcw, input bit irw,
                        input bit mw, input bit rw, input bit adr,
                        input bit srca, input logic [1:0] srcb,
                        input logic [1:0] res, input logic [2:0] alu);
        exp_t e;
        e.tag      = tag;
        e.v.pcw    = pcw;
        e.v.irw    = irw;
        e.v.mw     = mw;
        e.v.rw     = rw;
        e.v.adr    = adr;
        e.v.srca   = srca;
        e.v.srcb   = srcb;
        e.v.res    = res;
        e.v.imm    = Op;
        e.v.regsrc = {Op == 2'b01, Op == 2'b10};
        e.v.alu    = {1'b0, alu};
        exp_q.push_back(e);
    endtask

    // Start of a cycle: just after the rising edge, with noise on inputs
    // that must not matter outside the states that consume them.
    task automatic cyc();
        @(posedge clk);
        #1;
        ALUFlags  = 4'($urandom);
        mem_ready = 1'($urandom);
    endtask

    task automatic reset_cycle();
        cyc();
        rst       = 1'b0;
        m_flags   = 4'b0000;
        push("reset", 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'd0);
    endtask

    // stall < 0 means a random number of stalls (0..2)
    task automatic run_instr(input logic [31:0] instr, input int fstall,
                             input int mstall, input int xflags,
                             input bit abort_in_read);
        int  n;
        bit  load;
        logic [3:0] cmd;
        n = (fstall < 0) ? $urandom_range(0, 2) : fstall;
        for (int k = 0; k <= n; k++) begin
            cyc();
            rst   = 1'b1;
            Cond  = instr[31:28];
            Op    = instr[27:26];
            Funct = instr[25:20];
            Rd    = instr[15:12];
            mem_ready = (k == n);
            push("fetch", k == n, k == n, 0, 0, 0, 1, 2'b10, 2'b10, 3'd0);
        end
        cyc();
        push("decode", 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'd0);
        if (!cond_true(Cond, m_flags) || Op == 2'b11) return;
        load = Funct[0];
        cmd  = Funct[4:1];
        case (Op)
            2'b01: begin
                cyc();
                push("memadr", 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'd0);
                n = (mstall < 0) ? $urandom_range(0, 2) : mstall;
                for (int k = 0; k <= n; k++) begin
                    if (load && abort_in_read) begin
                        reset_cycle();
                        return;
                    end
                    cyc();
                    mem_ready = (k == n);
                    if (load) push("memread", 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'd0);
                    else      push("memwrite", 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'd0);
                end
                if (load) begin
                    cyc();
                    push("memwb", Rd == 4'd15, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'd0);
                end
            end
            2'b00: begin
                cyc();
                if (xflags >= 0) ALUFlags = 4'(xflags);
                push(Funct[5] ? "execi" : "execr", 0, 0, 0, 0, 0, 0,
                     Funct[5] ? 2'b01 : 2'b00, 2'b00, cmd_alu(cmd));
                if (Funct[0]) begin
                    m_flags[3:2] = ALUFlags[3:2];
                    if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
                        m_flags[1:0] = ALUFlags[1:0];
                end
                if (cmd != 4'b1010) begin
                    cyc();
                    push("aluwb", Rd == 4'd15, 0, 0, cmd_known(cmd), 0, 0,
                         2'b00, 2'b00, 3'd0);
                end
            end
            default: begin
                cyc();
                push("branch", 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'd0);
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
        if (w[27:26] == 2'b00 && $urandom_range(0, 3) != 0)
            w[24:21] = known_cmds[$urandom_range(0, 6)];
        if (w[15:12] == 4'd15 && $urandom_range(0, 1) == 0) w[15:12] = 4'd3;
        return w;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        obs_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{pcw: PCWrite, irw: IRWrite, mw: MemWrite, rw: RegWrite,
                        adr: AdrSrc, srca: ALUSrcA, srcb: ALUSrcB,
                        res: ResultSrc, imm: ImmSrc, regsrc: RegSrc,
                        alu: ALUControl};
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s @%0t: got %05h expected %05h", e.tag,
                             $time, act, e.v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        Cond      = 4'h0;
        Op        = 2'b00;
        Funct     = 6'h00;
        Rd        = 4'h0;
        ALUFlags  = 4'h0;
        mem_ready = 1'b0;

        reset_cycle();
        run_instr(32'h0a00003f, 0, 0, -1, 0);    // BEQ with Z=0: not taken
        run_instr(32'he2800004, 0, 0, 4'hF, 0);  // ADD imm, S=0: flags kept
        run_instr(32'he35100ff, 0, 0, 4'h4, 0);  // CMP sets Z
        run_instr(32'h0a00003f, 0, 0, -1, 0);    // BEQ now taken
        run_instr(32'he5901000, 0, 2, -1, 0);    // LDR, 2 read stalls
        run_instr(32'he5804000, 1, 1, -1, 0);    // STR with stalls
        run_instr(32'he5901000, 0, 0, -1, 1);    // LDR aborted by reset
        run_instr(32'h0a00003f, 0, 0, -1, 0);    // flags cleared: not taken
        run_instr(32'h1a00003f, 0, 0, -1, 0);    // BNE taken
        for (int i = 0; i < 300; i++) begin
            if (i % 97 == 50) run_instr(rand_instr(), -1, -1, -1, 1);
            else              run_instr(rand_instr(), -1, -1, -1, 0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
